// File: rtl/reg_block.sv
// reg_block: word-addressed register file on the peripheral bus.
// Holds ID, CTRL, STATUS, PEND (write-1-to-clear), MASK, SCRATCH and an
// optional one-shot countdown TIMER. Reads are returned one cycle after rd.
// Optional feature macro: REG_BLOCK_TIMER_EN enables the TIMER register,
// its countdown and the PEND[31] expiry source.
module reg_block #(
  parameter int          ADDR_W   = 4,
  parameter logic [31:0] ID_VALUE = 32'h5045_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic [31:0]       ctrl_o,
  input  logic [31:0]       status_i,
  input  logic [30:0]       event_i,
  output logic              irq_o
);

  logic [31:0] idx;
  logic [31:0] status_q;
  logic [31:0] ctrl_q;
  logic [31:0] pend_q;
  logic [31:0] mask_q;
  logic [31:0] scratch_q;
  logic [31:0] rd_val;
  logic [31:0] w1c;
  logic [31:0] pend_next;
  logic        expire;
  logic        wr_ctrl;
  logic        wr_pend;
  logic        wr_mask;
  logic        wr_scratch;

  assign idx        = 32'(addr);
  assign wr_ctrl    = wr && (idx == 32'd1);
  assign wr_pend    = wr && (idx == 32'd3);
  assign wr_mask    = wr && (idx == 32'd4);
  assign wr_scratch = wr && (idx == 32'd5);
  assign ctrl_o     = ctrl_q;

`ifdef REG_BLOCK_TIMER_EN
  logic [31:0] timer_q;
  logic [31:0] timer_next;
  logic        wr_timer;

  assign wr_timer = wr && (idx == 32'd6);

  // Countdown: a bus write overrides the decrement; the 1->0 step flags expiry.
  always_comb begin
    timer_next = timer_q;
    expire     = 1'b0;
    if (wr_timer) begin
      timer_next = data_i;
    end else if (ctrl_q[0] && (timer_q != 32'd0)) begin
      timer_next = timer_q - 32'd1;
      expire     = (timer_q == 32'd1);
    end
  end

  // Timer count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= 32'd0;
    end else begin
      timer_q <= timer_next;
    end
  end
`else
  assign expire = 1'b0;
`endif

  // Pending bits: clear by write-1, but a same-cycle set always survives.
  always_comb begin
    w1c       = wr_pend ? data_i : 32'd0;
    pend_next = (pend_q & ~w1c) | {expire, event_i};
  end

  // Read mux uses current register values, so a same-cycle write is not seen.
  always_comb begin
    rd_val = 32'd0;
    case (idx)
      32'd0:   rd_val = ID_VALUE;
      32'd1:   rd_val = ctrl_q;
      32'd2:   rd_val = status_q;
      32'd3:   rd_val = pend_q;
      32'd4:   rd_val = mask_q;
      32'd5:   rd_val = scratch_q;
`ifdef REG_BLOCK_TIMER_EN
      32'd6:   rd_val = timer_q;
`endif
      default: rd_val = 32'd0;
    endcase
  end

  // Register state, registered read data and the level interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q  <= 32'd0;
      ctrl_q    <= 32'd0;
      pend_q    <= 32'd0;
      mask_q    <= 32'd0;
      scratch_q <= 32'd0;
      data_o    <= 32'd0;
      irq_o     <= 1'b0;
    end else begin
      status_q <= status_i;
      pend_q   <= pend_next;
      irq_o    <= |(pend_q & mask_q);
      if (wr_ctrl) begin
        ctrl_q <= data_i;
      end
      if (wr_mask) begin
        mask_q <= data_i;
      end
      if (wr_scratch) begin
        scratch_q <= data_i;
      end
      if (rd) begin
        data_o <= rd_val;
      end
    end
  end

endmodule

// File: tb/tb_reg_block.sv
// tb_reg_block: scoreboard bench for reg_block.
// A behavioural model advances once per clock edge and queues the expected
// read responses and per-cycle output values; a monitor on the falling edge
// pops and compares them. Honours REG_BLOCK_TIMER_EN like the design.
module tb_reg_block;

  localparam logic [31:0] ID_CONST = 32'h5045_0001;

  logic        clk;
  logic        reset;
  logic        wr;
  logic        rd;
  logic [3:0]  addr;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [31:0] ctrl_o;
  logic [31:0] status_i;
  logic [30:0] event_i;
  logic        irq_o;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_ctrl_q[$];
  logic [31:0] exp_dout_q[$];
  logic        exp_irq_q[$];
  logic        resp_due_q[$];

  logic [31:0] m_ctrl;
  logic [31:0] m_pend;
  logic [31:0] m_mask;
  logic [31:0] m_scratch;
  logic [31:0] m_timer;
  logic [31:0] m_status;
  logic [31:0] m_dout;
  logic        m_irq;

  reg_block dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .rd       (rd),
    .addr     (addr),
    .data_i   (data_i),
    .data_o   (data_o),
    .ctrl_o   (ctrl_o),
    .status_i (status_i),
    .event_i  (event_i),
    .irq_o    (irq_o)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input int a);
    case (a)
      0:       return ID_CONST;
      1:       return m_ctrl;
      2:       return m_status;
      3:       return m_pend;
      4:       return m_mask;
      5:       return m_scratch;
`ifdef REG_BLOCK_TIMER_EN
      6:       return m_timer;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Drive one cycle of inputs, let the edge consume them, then advance the model.
  task automatic applyStimulus(input logic w, input logic r, input logic [3:0] a,
                               input logic [31:0] d, input logic [30:0] ev,
                               input logic [31:0] st, input logic rst);
    logic        irq_new;
    logic        expire;
    logic [31:0] w1c;
    wr       = w;
    rd       = r;
    addr     = a;
    data_i   = d;
    event_i  = ev;
    status_i = st;
    reset    = rst;
    @(posedge clk);
    if (rst) begin
      m_ctrl    = 32'd0;
      m_pend    = 32'd0;
      m_mask    = 32'd0;
      m_scratch = 32'd0;
      m_timer   = 32'd0;
      m_status  = 32'd0;
      m_dout    = 32'd0;
      m_irq     = 1'b0;
      resp_due_q.push_back(1'b0);
    end else begin
      if (r) begin
        m_dout = modelRead(int'(a));
        exp_rd_q.push_back(m_dout);
      end
      resp_due_q.push_back(r);
      irq_new = |(m_pend & m_mask);
      expire  = 1'b0;
`ifdef REG_BLOCK_TIMER_EN
      if (w && a == 4'd6) begin
        m_timer = d;
      end else if (m_ctrl[0] && m_timer > 0) begin
        m_timer = m_timer - 1;
        if (m_timer == 0) expire = 1'b1;
      end
`endif
      w1c    = (w && a == 4'd3) ? d : 32'd0;
      m_pend = (m_pend & ~w1c) | {expire, ev};
      if (w && a == 4'd1) m_ctrl    = d;
      if (w && a == 4'd4) m_mask    = d;
      if (w && a == 4'd5) m_scratch = d;
      m_status = st;
      m_irq    = irq_new;
    end
    exp_ctrl_q.push_back(m_ctrl);
    exp_irq_q.push_back(m_irq);
    exp_dout_q.push_back(m_dout);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 31'd0, 32'h1234_0000 + 32'(i), 1'b0);
  endtask

  task automatic wrReg(input logic [3:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, a, d, 31'd0, 32'hCAFE_0001, 1'b0);
  endtask

  task automatic rdReg(input logic [3:0] a);
    applyStimulus(1'b0, 1'b1, a, 32'd0, 31'd0, 32'hBEEF_0000 + 32'(a), 1'b0);
  endtask

  // Monitor: compares queued expectations against the DUT on the falling edge.
  always @(negedge clk) begin
    logic due;
    logic [31:0] e;
    if (exp_ctrl_q.size() > 0) begin
      checkOutput("ctrl_o", ctrl_o, exp_ctrl_q.pop_front());
      checkOutput("irq_o", {31'd0, irq_o}, {31'd0, exp_irq_q.pop_front()});
      e   = exp_dout_q.pop_front();
      due = resp_due_q.pop_front();
      if (due) begin
        if (exp_rd_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL data_o: response with no expectation, got %h expected none", data_o);
        end else begin
          checkOutput("data_o read", data_o, exp_rd_q.pop_front());
        end
      end else begin
        checkOutput("data_o hold", data_o, e);
      end
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic        w;
    logic        r;
    logic [3:0]  a;
    logic [31:0] d;
    logic [30:0] ev;
    tests_run    = 0;
    tests_failed = 0;
    wr = 0; rd = 0; addr = 0; data_i = 0; event_i = 0; status_i = 0; reset = 1;

    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 31'd0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 31'd0, 32'd0, 1'b1);

    for (int i = 0; i < 8; i++) rdReg(4'(i));

    applyStimulus(1'b1, 1'b1, 4'd5, 32'hA5A5_5A5A, 31'd0, 32'd7, 1'b0);
    rdReg(4'd5);

    wrReg(4'd4, 32'h0000_0004);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 31'h4, 32'd0, 1'b0);
    rdReg(4'd3);
    idle(2);
    wrReg(4'd3, 32'h4);
    rdReg(4'd3);
    idle(2);

    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 31'h4, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd3, 32'h4, 31'h4, 32'd0, 1'b0);
    rdReg(4'd3);
    wrReg(4'd3, 32'hFFFF_FFFF);

    wrReg(4'd6, 32'd5);
    wrReg(4'd1, 32'd1);
    wrReg(4'd4, 32'h8000_0000);
    for (int i = 0; i < 6; i++) rdReg(4'd3);
    rdReg(4'd6);
    wrReg(4'd6, 32'd20);
    idle(3);
    applyStimulus(1'b1, 1'b1, 4'd5, 32'h1, 31'h1, 32'h55, 1'b1);
    idle(1);
    wrReg(4'd6, 32'd9);
    rdReg(4'd6);
    rdReg(4'd2);

    for (int i = 0; i < 1500; i++) begin
      a  = 4'($urandom_range(0, 9));
      w  = ($urandom_range(0, 2) == 0);
      r  = $urandom_range(0, 1) == 1;
      d  = (a == 4'd6) ? 32'($urandom_range(0, 12)) : $urandom;
      ev = ($urandom_range(0, 7) == 0) ? (31'd1 << $urandom_range(0, 30)) : 31'd0;
      applyStimulus(w, r, a, d, ev, $urandom, $urandom_range(0, 299) == 0);
    end
    idle(3);

    tests_run++;
    if (exp_rd_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL read queue drain: got %0d left, expected 0", exp_rd_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
